// File: rtl/vga_console_pkg.sv
// ---------------------------------------------------------------------------
// vga_console_pkg
// Shared constants for the VGA text console: glyph and cell geometry, glyph
// bitmap width and character code width, plus the glyph bit lookup used by
// the pixel generator.
//   glyph_bit(bits, gx, gy) : bitmap bit for glyph column gx / row gy, or 0
//                             in the blank spacing column / row of the cell.
// ---------------------------------------------------------------------------
package vga_console_pkg;

  localparam int GLYPH_W    = 5;
  localparam int GLYPH_H    = 7;
  localparam int CELL_W     = 6;
  localparam int CELL_H     = 8;
  localparam int GLYPH_BITS = 35;
  localparam int CHAR_W     = 7;

  // Bitmap is row-major with bit GLYPH_BITS-1 as the top-left glyph pixel.
  function automatic logic glyph_bit(input logic [GLYPH_BITS-1:0] bits,
                                     input logic [2:0]            gx,
                                     input logic [2:0]            gy);
    logic [5:0] idx;
    idx = 6'(GLYPH_BITS - 1) - (6'(gy) * 6'(GLYPH_W) + 6'(gx));
    if (gx < 3'(GLYPH_W) && gy < 3'(GLYPH_H)) return bits[idx];
    return 1'b0;
  endfunction

endpackage

// File: rtl/text_pixel_gen.sv
// ---------------------------------------------------------------------------
// text_pixel_gen
// Character-cell pixel generator. Tracks the active-pixel strobe across a
// COLS x ROWS grid of 6x8 cells (each glyph pixel scaled 2^SCALE_LOG2 in
// both directions), addresses the text buffer, forwards the character code
// to the glyph ROM and emits a registered foreground pixel with an optional
// blinking block cursor. Latency from pixel_en to pixel_on is 2 cycles.
//
// Ports
//   clk, rst_n   : pixel clock, asynchronous active-low reset
//   frame_start  : one-cycle pulse in vertical blanking, restarts the grid
//   pixel_en     : high for every active pixel of a line
//   text_addr    : combinational text buffer address (row_base + cell_col)
//   char_code    : text buffer data for text_addr, same cycle
//   rom_addr     : registered character code to char_rom
//   rom_data     : glyph bitmap for rom_addr, combinational
//   cursor_en    : cursor enable
//   cursor_addr  : linear cell index of the cursor
//   pixel_on     : registered foreground pixel
//   pixel_valid  : pixel_en delayed by 2 cycles
// ---------------------------------------------------------------------------
module text_pixel_gen
  import vga_console_pkg::*;
#(
  parameter int COLS       = 20,
  parameter int ROWS       = 4,
  parameter int SCALE_LOG2 = 2,
  parameter int BLINK_LOG2 = 4,
  parameter int AW         = $clog2(COLS * ROWS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_start,
  input  logic                  pixel_en,
  output logic [AW-1:0]         text_addr,
  input  logic [CHAR_W-1:0]     char_code,
  output logic [CHAR_W-1:0]     rom_addr,
  input  logic [GLYPH_BITS-1:0] rom_data,
  input  logic                  cursor_en,
  input  logic [AW-1:0]         cursor_addr,
  output logic                  pixel_on,
  output logic                  pixel_valid
);

  localparam int CW = $clog2(COLS + 1);
  localparam int RW = $clog2(ROWS + 1);
  localparam int SW = SCALE_LOG2;

  // One past the last cell: the saturated "outside the grid" value.
  localparam logic [CW-1:0] COL_END = CW'(COLS);
  localparam logic [RW-1:0] ROW_END = RW'(ROWS);
  localparam logic [2:0]    GX_LAST = 3'(CELL_W - 1);
  localparam logic [2:0]    GY_LAST = 3'(CELL_H - 1);

  // Position counters and their next values.
  logic [SW-1:0] sub_x, sub_x_n, sub_y, sub_y_n;
  logic [2:0]    gx, gx_n, gy, gy_n;
  logic [CW-1:0] cell_col, cell_col_n;
  logic [RW-1:0] cell_row, cell_row_n;
  logic [AW-1:0] row_base, row_base_n;

  logic                pen_q;       // pixel_en delayed one cycle
  logic                line_end;
  logic                started;     // a frame_start has been seen since reset
  logic [BLINK_LOG2:0] blink_cnt;
  logic                blink_on;

  // Stage 1 registers.
  logic       valid1;
  logic [2:0] gx1, gy1;
  logic       in_grid1;
  logic       is_cursor1;

  assign line_end  = pen_q & ~pixel_en;
  assign text_addr = row_base + AW'(cell_col);
  assign blink_on  = ~blink_cnt[BLINK_LOG2];

  always_comb begin
    // NOTE: every next-state value gets a default first so no path through
    // the if-chain leaves one unassigned, which would infer a latch.
    sub_x_n    = sub_x;
    gx_n       = gx;
    cell_col_n = cell_col;
    sub_y_n    = sub_y;
    gy_n       = gy;
    cell_row_n = cell_row;
    row_base_n = row_base;

    if (frame_start) begin
      sub_x_n    = '0;
      gx_n       = '0;
      cell_col_n = '0;
      sub_y_n    = '0;
      gy_n       = '0;
      cell_row_n = '0;
      row_base_n = '0;
    end else if (line_end) begin
      sub_x_n    = '0;
      gx_n       = '0;
      cell_col_n = '0;
      sub_y_n    = sub_y + 1'b1;
      if (sub_y == '1) begin
        if (gy == GY_LAST) begin
          gy_n = '0;
          if (cell_row != ROW_END) begin
            cell_row_n = cell_row + 1'b1;
            row_base_n = row_base + AW'(COLS);
          end
        end else begin
          gy_n = gy + 1'b1;
        end
      end
    end else if (pixel_en) begin
      sub_x_n = sub_x + 1'b1;
      if (sub_x == '1) begin
        if (gx == GX_LAST) begin
          gx_n = '0;
          if (cell_col != COL_END) cell_col_n = cell_col + 1'b1;
        end else begin
          gx_n = gx + 1'b1;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_x     <= '0;
      gx        <= '0;
      cell_col  <= '0;
      sub_y     <= '0;
      gy        <= '0;
      cell_row  <= '0;
      row_base  <= '0;
      pen_q     <= 1'b0;
      started   <= 1'b0;
      blink_cnt <= '0;
    end else begin
      sub_x    <= sub_x_n;
      gx       <= gx_n;
      cell_col <= cell_col_n;
      sub_y    <= sub_y_n;
      gy       <= gy_n;
      cell_row <= cell_row_n;
      row_base <= row_base_n;
      pen_q    <= pixel_en;
      if (frame_start) begin
        started   <= 1'b1;
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // Stage 1: capture the cell context alongside the character code so it
  // lines up with rom_data one cycle later. Output stays dark until the
  // counters have been aligned by a frame_start.
  // NOTE: the pipeline registers are reset too, not only the control bits:
  // pixel_on must read 0 the instant rst_n falls, and stale cell context
  // must not leak out after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid1     <= 1'b0;
      rom_addr   <= '0;
      gx1        <= '0;
      gy1        <= '0;
      in_grid1   <= 1'b0;
      is_cursor1 <= 1'b0;
    end else begin
      valid1 <= pixel_en & started;
      if (pixel_en) begin
        rom_addr   <= char_code;
        gx1        <= gx;
        gy1        <= gy;
        in_grid1   <= (cell_col < COL_END) && (cell_row < ROW_END);
        is_cursor1 <= cursor_en && (text_addr == cursor_addr);
      end
    end
  end

  // Stage 2: glyph bit select; the cursor inverts the whole 6x8 cell,
  // spacing column and row included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_on    <= 1'b0;
      pixel_valid <= 1'b0;
    end else begin
      pixel_on    <= valid1 & in_grid1 &
                     (glyph_bit(rom_data, gx1, gy1) ^ (is_cursor1 & blink_on));
      pixel_valid <= pen_q;
    end
  end

endmodule

// File: tb/tb_text_pixel_gen.sv
// ---------------------------------------------------------------------------
// tb_text_pixel_gen
// Self-checking bench for text_pixel_gen (COLS=20, ROWS=4, SCALE_LOG2=2,
// BLINK_LOG2=4). A reference model tracks screen coordinates (x, y) and
// derives the cell, glyph position, address and expected pixel with plain
// arithmetic; the text buffer and glyph ROM are bench arrays.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_text_pixel_gen;

  localparam int COLS = 20;
  localparam int ROWS = 4;
  localparam int S    = 2;
  localparam int AW   = 7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          frame_start;
  logic          pixel_en;
  logic [AW-1:0] text_addr;
  logic [6:0]    char_code;
  logic [6:0]    rom_addr;
  logic [34:0]   rom_data;
  logic          cursor_en;
  logic [AW-1:0] cursor_addr;
  logic          pixel_on;
  logic          pixel_valid;

  text_pixel_gen #(.COLS(COLS), .ROWS(ROWS), .SCALE_LOG2(S), .BLINK_LOG2(4)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pixel_en(pixel_en),
    .text_addr(text_addr), .char_code(char_code), .rom_addr(rom_addr),
    .rom_data(rom_data), .cursor_en(cursor_en), .cursor_addr(cursor_addr),
    .pixel_on(pixel_on), .pixel_valid(pixel_valid)
  );

  always #5 clk = ~clk;

  // Text buffer and glyph ROM models.
  logic [6:0]  text_mem  [128];
  logic [34:0] glyph_tbl [128];
  logic [34:0] gold_a;

  always_comb char_code = text_mem[text_addr];
  always_comb rom_data  = glyph_tbl[rom_addr];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model state.
  int mx, my, m_frames;
  bit m_pen, m_started;
  bit e_on_prev, e_val_prev;
  int px_prev, py_prev;
  bit cap [32][64];
  int lit, oob;

  task automatic model_reset();
    mx = 0; my = 0; m_frames = 0; m_pen = 0; m_started = 0;
    e_on_prev = 0; e_val_prev = 0;
  endtask

  task automatic tick(input bit en, input bit fs);
    int cc, cr, gx, gy, addr;
    bit gb, curs, exp_on;
    logic [34:0] g;
    @(negedge clk);
    pixel_en = en; frame_start = fs;
    #1;
    cc = (mx >> S) / 6;  if (cc > COLS) cc = COLS;
    cr = (my >> S) / 8;  if (cr > ROWS) cr = ROWS;
    gx = (mx >> S) % 6;
    gy = (my >> S) % 8;
    addr = (cr * COLS + cc) % 128;
    check("text_addr", text_addr, addr);
    g  = glyph_tbl[text_mem[addr]];
    gb = (gx < 5 && gy < 7) ? g[34 - (gy * 5 + gx)] : 1'b0;
    curs = cursor_en && (addr == int'(cursor_addr)) && ((m_frames % 32) < 16);
    exp_on = en && m_started && cc < COLS && cr < ROWS && (gb ^ curs);
    @(posedge clk); #1;
    check("pixel_on", pixel_on, e_on_prev);
    check("pixel_valid", pixel_valid, e_val_prev);
    if (e_val_prev) begin
      if (py_prev < 32 && px_prev < 64) cap[py_prev][px_prev] = pixel_on;
      if (pixel_on && (px_prev >= 480 || py_prev >= 128)) oob++;
      if (pixel_on && px_prev >= 24 && px_prev < 48 && py_prev >= 32 && py_prev < 64) lit++;
    end
    e_on_prev = exp_on; e_val_prev = en; px_prev = mx; py_prev = my;
    if (fs) begin
      mx = 0; my = 0; m_frames++; m_started = 1;
    end else if (m_pen && !en) begin
      mx = 0; my++;
    end else if (en) begin
      mx++;
    end
    m_pen = en;
  endtask

  task automatic scan_line(input int len, input int gap);
    for (int i = 0; i < len; i++) tick(1'b1, 1'b0);
    for (int i = 0; i < gap; i++) tick(1'b0, 1'b0);
  endtask

  task automatic new_frame();
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; pixel_en = 1'b0; frame_start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic check_a_region(input string tag);
    int bad, spc;
    bad = 0; spc = 0;
    for (int y = 0; y < 28; y++)
      for (int x = 0; x < 20; x++)
        if (cap[y][x] != gold_a[34 - ((y / 4) * 5 + x / 4)]) bad++;
    for (int y = 0; y < 32; y++)
      for (int x = 20; x < 24; x++)
        if (cap[y][x]) spc++;
    check({tag, "_glyph_mismatches"}, bad, 0);
    check({tag, "_spacing_lit"}, spc, 0);
  endtask

  typedef struct {
    logic en; logic fs; logic ce;
    logic exp_on; logic exp_valid; logic [6:0] exp_rom; logic [AW-1:0] exp_addr;
  } rst_vec_t;

  typedef struct { int x; int y; bit exp; } gpt_t;

  rst_vec_t rv [4];
  gpt_t     gp [12];

  initial begin
    logic [63:0] r;
    int exp_lit;

    rv[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0};
    rv[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 7'd0, 7'd0};
    rv[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 7'd0, 7'd0};
    rv[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 7'd0};

    // 'A': 01110 / 10001 / 10001 / 11111 / 10001 / 10001 / 10001, 4x scale.
    gp[0]  = '{0, 0, 1'b0};   gp[1]  = '{4, 0, 1'b1};
    gp[2]  = '{16, 0, 1'b0};  gp[3]  = '{0, 4, 1'b1};
    gp[4]  = '{8, 4, 1'b0};   gp[5]  = '{16, 4, 1'b1};
    gp[6]  = '{9, 13, 1'b1};  gp[7]  = '{20, 0, 1'b0};
    gp[8]  = '{23, 12, 1'b0}; gp[9]  = '{0, 28, 1'b0};
    gp[10] = '{4, 24, 1'b0};  gp[11] = '{0, 27, 1'b1};

    gold_a = 35'b01110_10001_10001_11111_10001_10001_10001;
    for (int i = 0; i < 128; i++) begin
      r = {$urandom, $urandom};
      glyph_tbl[i] = (i <= 32) ? 35'd0 : r[34:0];
    end
    glyph_tbl[8'h41] = gold_a;
    for (int i = 0; i < 128; i++) text_mem[i] = 7'h20;

    rst_n = 1'b0; pixel_en = 1'b0; frame_start = 1'b0;
    cursor_en = 1'b0; cursor_addr = '0;
    model_reset();

    // Reset: toggle inputs while held in reset.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pixel_en = rv[i].en; frame_start = rv[i].fs; cursor_en = rv[i].ce;
      #1;
      check("rst_pixel_on", pixel_on, rv[i].exp_on);
      check("rst_pixel_valid", pixel_valid, rv[i].exp_valid);
      check("rst_rom_addr", rom_addr, rv[i].exp_rom);
      check("rst_text_addr", text_addr, rv[i].exp_addr);
    end
    @(negedge clk);
    pixel_en = 1'b0; frame_start = 1'b0; cursor_en = 1'b0;
    rst_n = 1'b1;
    model_reset();

    // Before any frame_start the output stays dark.
    scan_line(30, 2);
    scan_line(30, 2);

    // Single glyph in cell 0.
    text_mem[0] = 7'h41;
    new_frame();
    for (int l = 0; l < 32; l++) scan_line(60, 2);
    for (int i = 0; i < 12; i++)
      check($sformatf("glyph_pt_%0d_%0d", gp[i].x, gp[i].y), cap[gp[i].y][gp[i].x], gp[i].exp);
    check_a_region("glyph");

    // Async reset in the middle of a lit run.
    new_frame();
    for (int i = 0; i < 11; i++) tick(1'b1, 1'b0);
    check("pre_reset_on", pixel_on, 1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_pixel_on", pixel_on, 0);
    check("async_pixel_valid", pixel_valid, 0);
    pixel_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    scan_line(30, 2);
    scan_line(30, 2);
    for (int y = 0; y < 32; y++) for (int x = 0; x < 64; x++) cap[y][x] = 0;
    new_frame();
    for (int l = 0; l < 32; l++) scan_line(30, 2);
    check_a_region("recovery");

    // Addressing over a full frame with random text.
    for (int i = 0; i < 128; i++) text_mem[i] = 7'($urandom_range(0, 127));
    oob = 0;
    new_frame();
    for (int l = 0; l < 132; l++) begin
      if (l % 32 == 0 || l >= 127) scan_line(486, 2);
      else scan_line(30, 2);
    end
    check("outside_grid_lit", oob, 0);

    // Frame restart mid-line in cell row 2.
    new_frame();
    for (int l = 0; l < 70; l++) scan_line(40, 2);
    for (int i = 0; i < 100; i++) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    for (int i = 0; i < 50; i++) tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check("restart_text_addr", text_addr, 0);
    for (int l = 0; l < 3; l++) scan_line(60, 2);

    // Cursor blink on cell 21 = (row 1, col 1), blank text.
    do_reset();
    for (int i = 0; i < 128; i++) text_mem[i] = 7'h20;
    cursor_en = 1'b1; cursor_addr = 7'd21;
    for (int f = 1; f <= 32; f++) begin
      new_frame();
      if (f == 1 || f == 15 || f == 16 || f == 31 || f == 32) begin
        lit = 0;
        for (int l = 0; l < 64; l++) scan_line(50, 2);
        exp_lit = ((f % 32) < 16) ? 24 * 32 : 0;
        check($sformatf("cursor_lit_frame%0d", f), lit, exp_lit);
      end
    end
    cursor_en = 1'b0;
    new_frame();
    lit = 0;
    for (int l = 0; l < 64; l++) scan_line(50, 2);
    check("cursor_disabled_lit", lit, 0);

    // Randomised frames: random text, cursor and line lengths.
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 128; i++) text_mem[i] = 7'($urandom_range(0, 127));
      cursor_en = 1'($urandom_range(0, 1));
      cursor_addr = 7'($urandom_range(0, COLS * ROWS - 1));
      new_frame();
      for (int l = 0; l < 40; l++) scan_line($urandom_range(1, 500), $urandom_range(1, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
